// File: rtl/pig_pkg.sv
// Shared types and helpers for the Pig match scheduler: state encoding,
// dice constants and a saturating adder.
package pig_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        WAIT_CMD = 3'd1,
        ROLL     = 3'd2,
        APPLY    = 3'd3,
        BANK     = 3'd4,
        NEXT     = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [2:0] DICE_BUST = 3'd1;
    localparam logic [2:0] DICE_MIN  = 3'd2;
    localparam logic [2:0] DICE_MAX  = 3'd6;

    // a + b clamped to 2^w - 1; callers size-cast the result to their width
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? 32'(lim) : 32'(sum);
    endfunction

endpackage

// File: rtl/pig_score_bank.sv
// Per-player banked score registers with a saturating add-and-write port,
// clear-all, and a combinational view of the selected player's would-be sum.
module pig_score_bank
    import pig_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [1:0]                     idx,
    input  logic [SCORE_W-1:0]             add_val,
    output logic [SCORE_W-1:0]             sum_score,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat
);

    logic [SCORE_W-1:0] score [NUM_PLAYERS];
    logic [SCORE_W-1:0] sel_score;

    always_comb begin
        sel_score = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (idx == 2'(i)) sel_score = score[i];
        end
        sum_score = SCORE_W'(sat_add(32'(sel_score), 32'(add_val), SCORE_W));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (clear)
                    score[i] <= '0;
                else if (wr_en && idx == 2'(i))
                    score[i] <= sum_score;
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
        assign score_flat[g*SCORE_W +: SCORE_W] = score[g];
    end

endmodule

// File: rtl/pig_turn_sched.sv
// Pig match scheduler: turn FSM, shared dice-roller handshake and turn total.
// Build option PIG_AUTO_BANK_EN banks automatically once a roll reaches TARGET.
//
// state    | meaning
// IDLE     | no match; wait for start
// WAIT_CMD | active player may roll or hold
// ROLL     | dice_req high, waiting for dice_ack
// APPLY    | fold captured die into turn total
// BANK     | add turn total to active player's score, check for win
// NEXT     | advance to the next player
// DONE     | winner latched, scores frozen until start
module pig_turn_sched
    import pig_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TARGET      = 100,
    parameter int SCORE_W     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_PLAYERS-1:0]         roll_btn,
    input  logic [NUM_PLAYERS-1:0]         hold_btn,
    output logic                           dice_req,
    input  logic                           dice_ack,
    input  logic [2:0]                     dice_val,
    output logic [1:0]                     active_player,
    output logic [SCORE_W-1:0]             turn_total,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat,
    output logic                           winner_valid,
    output logic [1:0]                     winner,
    output logic                           bad_roll,
    output logic [STATE_W-1:0]             state
);

    localparam logic [SCORE_W-1:0] TARGET_S = SCORE_W'(TARGET);
    localparam logic [1:0]         LAST_P   = 2'(NUM_PLAYERS - 1);

    state_t             st;
    logic [2:0]         dice_cap;
    logic               roll_sel;
    logic               hold_sel;
    logic [SCORE_W-1:0] new_tt;
    logic [SCORE_W-1:0] bank_add;
    logic [SCORE_W-1:0] sum_score;
    logic               auto_bank;
    logic               bank_clear;

    assign state = st;

    always_comb begin
        roll_sel = 1'b0;
        hold_sel = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active_player == 2'(i)) begin
                roll_sel = roll_btn[i];
                hold_sel = hold_btn[i];
            end
        end
    end

    assign new_tt     = SCORE_W'(sat_add(32'(turn_total), 32'(dice_cap), SCORE_W));
    assign bank_clear = start && (st == IDLE || st == DONE);

`ifdef PIG_AUTO_BANK_EN
    // In APPLY the bank previews score + the post-roll turn total
    assign bank_add  = (st == APPLY) ? new_tt : turn_total;
    assign auto_bank = (sum_score >= TARGET_S);
`else
    assign bank_add  = turn_total;
    assign auto_bank = 1'b0;
`endif

    pig_score_bank #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .SCORE_W     (SCORE_W)
    ) u_bank (
        .clock      (clock),
        .reset      (reset),
        .clear      (bank_clear),
        .wr_en      (st == BANK),
        .idx        (active_player),
        .add_val    (bank_add),
        .sum_score  (sum_score),
        .score_flat (score_flat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st            <= IDLE;
            active_player <= '0;
            turn_total    <= '0;
            dice_cap      <= '0;
            winner        <= '0;
            winner_valid  <= 1'b0;
            dice_req      <= 1'b0;
            bad_roll      <= 1'b0;
        end else begin
            bad_roll <= 1'b0;
            case (st)
                IDLE, DONE: begin
                    if (start) begin
                        st            <= WAIT_CMD;
                        turn_total    <= '0;
                        active_player <= '0;
                        winner_valid  <= 1'b0;
                    end
                end
                WAIT_CMD: begin
                    if (hold_sel) begin
                        st <= BANK;
                    end else if (roll_sel) begin
                        st       <= ROLL;
                        dice_req <= 1'b1;
                    end
                end
                ROLL: begin
                    if (dice_ack) begin
                        dice_cap <= dice_val;
                        dice_req <= 1'b0;
                        st       <= APPLY;
                    end
                end
                APPLY: begin
                    if (dice_cap == DICE_BUST) begin
                        turn_total <= '0;
                        st         <= NEXT;
                    end else if (dice_cap >= DICE_MIN && dice_cap <= DICE_MAX) begin
                        turn_total <= new_tt;
                        st         <= auto_bank ? BANK : WAIT_CMD;
                    end else begin
                        bad_roll <= 1'b1;
                        st       <= WAIT_CMD;
                    end
                end
                BANK: begin
                    turn_total <= '0;
                    if (sum_score >= TARGET_S) begin
                        winner       <= active_player;
                        winner_valid <= 1'b1;
                        st           <= DONE;
                    end else begin
                        st <= NEXT;
                    end
                end
                NEXT: begin
                    active_player <= (active_player == LAST_P) ? 2'd0 : active_player + 2'd1;
                    st            <= WAIT_CMD;
                end
                default: begin
                    st           <= IDLE;
                    dice_req     <= 1'b0;
                    winner_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pig_turn_sched.sv
// Directed bench for pig_turn_sched with two players, target 100, 8-bit scores.
module tb_pig_turn_sched;

    localparam int NP = 2;
    localparam int SW = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [NP-1:0]   roll_btn;
    logic [NP-1:0]   hold_btn;
    logic            dice_req;
    logic            dice_ack;
    logic [2:0]      dice_val;
    logic [1:0]      active_player;
    logic [SW-1:0]   turn_total;
    logic [NP*SW-1:0] score_flat;
    logic            winner_valid;
    logic [1:0]      winner;
    logic            bad_roll;
    logic [2:0]      state;

    int checks = 0;
    int errors = 0;

    pig_turn_sched #(.NUM_PLAYERS(NP), .TARGET(100), .SCORE_W(SW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .roll_btn      (roll_btn),
        .hold_btn      (hold_btn),
        .dice_req      (dice_req),
        .dice_ack      (dice_ack),
        .dice_val      (dice_val),
        .active_player (active_player),
        .turn_total    (turn_total),
        .score_flat    (score_flat),
        .winner_valid  (winner_valid),
        .winner        (winner),
        .bad_roll      (bad_roll),
        .state         (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic press_roll(input int p);
        roll_btn[p] = 1'b1;
        tick();
        roll_btn = '0;
    endtask

    task automatic press_hold(input int p);
        hold_btn[p] = 1'b1;
        tick();
        hold_btn = '0;
    endtask

    task automatic ack(input logic [2:0] v);
        dice_ack = 1'b1;
        dice_val = v;
        tick();
        dice_ack = 1'b0;
        dice_val = 3'd0;
    endtask

    // roll, ack, then APPLY edge: back in WAIT_CMD for values 2..6
    task automatic roll(input int p, input logic [2:0] v);
        press_roll(p);
        ack(v);
        tick();
    endtask

    // hold with no win: BANK, NEXT, back in WAIT_CMD
    task automatic hold_turn(input int p);
        press_hold(p);
        tick();
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        roll_btn = '0;
        hold_btn = '0;
        dice_ack = 1'b0;
        dice_val = 3'd0;
        tick();
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_req", 32'(dice_req), 0);
        check("rst_tt", 32'(turn_total), 0);
        check("rst_scores", 32'(score_flat), 0);
        check("rst_active", 32'(active_player), 0);
        check("rst_winv", 32'(winner_valid), 0);
        check("rst_winner", 32'(winner), 0);
        check("rst_bad", 32'(bad_roll), 0);
        reset = 1'b0;
        tick();
        check("idle_hold", 32'(state), 0);

        pulse_start();
        check("start_wait", 32'(state), 1);

        // p0 rolls 4 then 5, then holds
        press_roll(0);
        check("roll_req", 32'(dice_req), 1);
        check("roll_state", 32'(state), 2);
        ack(3'd4);
        check("apply_state", 32'(state), 3);
        check("apply_req", 32'(dice_req), 0);
        check("tt_before_apply", 32'(turn_total), 0);
        tick();
        check("tt_4", 32'(turn_total), 4);
        check("after_apply", 32'(state), 1);
        roll(0, 3'd5);
        check("tt_9", 32'(turn_total), 9);
        press_hold(0);
        check("bank_state", 32'(state), 4);
        check("score0_pre_bank", 32'(score_flat[7:0]), 0);
        tick();
        check("score0_9", 32'(score_flat[7:0]), 9);
        check("tt_cleared", 32'(turn_total), 0);
        check("next_state", 32'(state), 5);
        check("active_in_next", 32'(active_player), 0);
        tick();
        check("active_1", 32'(active_player), 1);

        // p1 busts with a 1
        press_roll(1);
        check("p1_roll", 32'(state), 2);
        ack(3'd1);
        tick();
        check("bust_tt", 32'(turn_total), 0);
        check("bust_next", 32'(state), 5);
        check("bust_active_hold", 32'(active_player), 1);
        tick();
        check("bust_active_0", 32'(active_player), 0);
        check("bust_score1", 32'(score_flat[15:8]), 0);

        // inactive player's roll is ignored
        press_roll(1);
        check("inactive_req", 32'(dice_req), 0);
        check("inactive_state", 32'(state), 1);

        // p0 rolls 3, then hold+roll together: hold wins
        roll(0, 3'd3);
        check("tt_3", 32'(turn_total), 3);
        roll_btn[0] = 1'b1;
        hold_btn[0] = 1'b1;
        tick();
        roll_btn = '0;
        hold_btn = '0;
        check("both_bank", 32'(state), 4);
        check("both_no_req", 32'(dice_req), 0);
        tick();
        check("score0_12", 32'(score_flat[7:0]), 12);
        tick();
        check("both_active_1", 32'(active_player), 1);

        // delayed ack: dice_req held for 5 cycles
        press_roll(1);
        check("delay_req_c0", 32'(dice_req), 1);
        for (int c = 1; c < 5; c++) begin
            roll_btn[1] = 1'b1;
            tick();
            roll_btn = '0;
            check("delay_req", 32'(dice_req), 1);
        end
        ack(3'd6);
        check("delay_drop", 32'(dice_req), 0);
        tick();
        check("tt_6", 32'(turn_total), 6);

        // illegal die value
        press_roll(1);
        ack(3'd7);
        tick();
        check("bad_pulse", 32'(bad_roll), 1);
        check("bad_tt", 32'(turn_total), 6);
        check("bad_state", 32'(state), 1);
        tick();
        check("bad_clear", 32'(bad_roll), 0);

        // stray ack and start in WAIT_CMD ignored
        ack(3'd5);
        check("stray_ack_state", 32'(state), 1);
        check("stray_ack_tt", 32'(turn_total), 6);
        pulse_start();
        check("start_ign_state", 32'(state), 1);
        check("start_ign_score", 32'(score_flat[7:0]), 12);

        hold_turn(1);
        check("score1_6", 32'(score_flat[15:8]), 6);
        check("wrap_active_0", 32'(active_player), 0);

        // take p0 to 96
        for (int r = 0; r < 14; r++) roll(0, 3'd6);
        check("tt_84", 32'(turn_total), 84);
        hold_turn(0);
        check("score0_96", 32'(score_flat[7:0]), 96);
        hold_turn(1);
        check("pass_score1", 32'(score_flat[15:8]), 6);
        check("pass_active", 32'(active_player), 0);

        // p0 wins at exactly TARGET
        roll(0, 3'd4);
        press_hold(0);
        tick();
        check("win_state", 32'(state), 6);
        check("win_score0", 32'(score_flat[7:0]), 100);
        check("win_valid", 32'(winner_valid), 1);
        check("win_who", 32'(winner), 0);
        roll_btn = '1;
        hold_btn = '1;
        tick();
        tick();
        roll_btn = '0;
        hold_btn = '0;
        check("done_state", 32'(state), 6);
        check("done_req", 32'(dice_req), 0);
        check("done_frozen", 32'(score_flat), 32'h0664);
        pulse_start();
        check("restart_state", 32'(state), 1);
        check("restart_scores", 32'(score_flat), 0);
        check("restart_winv", 32'(winner_valid), 0);
        check("restart_active", 32'(active_player), 0);

        // turn total and score saturate at 255
        for (int r = 0; r < 43; r++) roll(0, 3'd6);
        check("tt_sat", 32'(turn_total), 255);
        press_hold(0);
        tick();
        check("score_sat", 32'(score_flat[7:0]), 255);
        check("sat_win", 32'(state), 6);
        pulse_start();

        // player 1 wins
        hold_turn(0);
        for (int r = 0; r < 17; r++) roll(1, 3'd6);
        press_hold(1);
        tick();
        check("p1_win_state", 32'(state), 6);
        check("p1_win_who", 32'(winner), 1);
        check("p1_win_score", 32'(score_flat[15:8]), 102);
        pulse_start();

        // asynchronous reset in ROLL
        press_roll(0);
        check("pre_rst_req", 32'(dice_req), 1);
        #2 reset = 1'b1;
        #1;
        check("async_req", 32'(dice_req), 0);
        check("async_state", 32'(state), 0);
        tick();
        reset = 1'b0;
        ack(3'd5);
        tick();
        check("late_ack_state", 32'(state), 0);
        check("late_ack_tt", 32'(turn_total), 0);
        check("late_ack_req", 32'(dice_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
